seven_segment_decoder: RTL and testbench

Receive-side counterpart of the two-digit seven-segment encoder: observes the two active-low segment buses (tens and ones) that drive the board HEX displays, filters out transient patterns, decodes stable ones back into a binary value 0..99, and delivers each new value over a valid/ready handshake. It sits on the board-test path, reading back the display bus so adder results can be checked automatically instead of by eye.

---
 rtl/seven_segment_decoder.sv | 152 +++++++++++++++
 tb/tb_seven_segment_decoder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_decoder.sv
// Seven-segment readback: debounces the two HEX buses, decodes 0..99
// and hands each new stable value out over valid/ready.
module seven_segment_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int COUNT_W       = 8
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [6:0]         hex1_in,
    input  logic [6:0]         hex0_in,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [6:0]         value,
    output logic [3:0]         digit1,
    output logic [3:0]         digit0,
    output logic               blank1,
    output logic               blank0,
    output logic               out_invalid,
    output logic               overflow,
    output logic [COUNT_W-1:0] accept_count
);

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    typedef enum logic {
        EMPTY,
        FULL
    } state_t;

    state_t       state_q, state_d;
    logic [13:0]  cand_q, cand_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [13:0]  last_q;
    logic         have_last_q;
    logic [13:0]  pair;
    logic         reached;
    logic         accept;
    logic         load;
    logic         drop;

    logic [5:0]   dec1, dec0;
    logic         r_inv;
    logic [3:0]   r_d1, r_d0;
    logic [6:0]   r_val;

    // {is_symbol, is_blank, digit}
    function automatic logic [5:0] seg_decode(input logic [6:0] p);
        logic [5:0] r;
        unique case (p)
            7'b0000001: r = {2'b10, 4'd0};
            7'b1001111: r = {2'b10, 4'd1};
            7'b0010010: r = {2'b10, 4'd2};
            7'b0000110: r = {2'b10, 4'd3};
            7'b1001100: r = {2'b10, 4'd4};
            7'b0100100: r = {2'b10, 4'd5};
            7'b0100000: r = {2'b10, 4'd6};
            7'b0001111: r = {2'b10, 4'd7};
            7'b0000000: r = {2'b10, 4'd8};
            7'b0000100: r = {2'b10, 4'd9};
            7'b1111111: r = {2'b11, 4'd0};
            default:    r = 6'd0;
        endcase
        return r;
    endfunction

    assign pair = {hex1_in, hex0_in};

    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (pair != cand_q) begin
            cand_d = pair;
            cnt_d  = 8'd1;
        end else if (cnt_q < STABLE) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Accept only on the edge the count arrives at the threshold
    assign reached = (cnt_d == STABLE) &&
                     ((cnt_q != STABLE) || (pair != cand_q));
    assign accept  = reached && (!have_last_q || (cand_d != last_q));

    assign dec1  = seg_decode(cand_d[13:7]);
    assign dec0  = seg_decode(cand_d[6:0]);
    assign r_inv = !dec1[5] || !dec0[5];
    assign r_d1  = r_inv ? 4'd0 : dec1[3:0];
    assign r_d0  = r_inv ? 4'd0 : dec0[3:0];
    assign r_val = ({3'b000, r_d1} * 7'd10) + {3'b000, r_d0};

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        drop    = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    load    = 1'b1;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (out_ready) begin
                    if (accept) load = 1'b1;
                    else state_d = EMPTY;
                end else if (accept) begin
                    drop = 1'b1;
                end
            end
        endcase
    end

    assign out_valid = (state_q == FULL);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= EMPTY;
            cand_q       <= 14'h3FFF;
            cnt_q        <= 8'd0;
            last_q       <= 14'd0;
            have_last_q  <= 1'b0;
            value        <= 7'd0;
            digit1       <= 4'd0;
            digit0       <= 4'd0;
            blank1       <= 1'b0;
            blank0       <= 1'b0;
            out_invalid  <= 1'b0;
            overflow     <= 1'b0;
            accept_count <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                last_q      <= cand_d;
                have_last_q <= 1'b1;
                if (accept_count != '1)
                    accept_count <= accept_count + 1'b1;
            end
            if (load) begin
                value       <= r_val;
                digit1      <= r_d1;
                digit0      <= r_d0;
                blank1      <= dec1[4];
                blank0      <= dec0[4];
                out_invalid <= r_inv;
            end
            if (drop) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Directed bench for seven_segment_decoder with a queue scoreboard
// checked at every valid/ready transfer.
module tb_seven_segment_decoder;

    logic       clock = 1'b0;
    logic       resetn;
    logic [6:0] hex1_in, hex0_in;
    logic       out_ready;
    logic       out_valid;
    logic [6:0] value;
    logic [3:0] digit1, digit0;
    logic       blank1, blank0;
    logic       out_invalid;
    logic       overflow;
    logic [7:0] accept_count;

    int tests = 0;
    int fails = 0;

    logic [17:0] sbq[$];
    logic [6:0]  seg [0:9] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };
    localparam logic [6:0] BLK = 7'b1111111;

    seven_segment_decoder #(
        .STABLE_CYCLES(4),
        .COUNT_W(8)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .hex1_in(hex1_in),
        .hex0_in(hex0_in),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .value(value),
        .digit1(digit1),
        .digit0(digit0),
        .blank1(blank1),
        .blank0(blank0),
        .out_invalid(out_invalid),
        .overflow(overflow),
        .accept_count(accept_count)
    );

    always #5 clock = ~clock;

    // {inv, blank1, blank0, digit1, digit0, value}
    function automatic logic [17:0] exp_res(int t, int o, bit bt, bit bo,
                                            bit inv);
        logic [3:0] d1, d0;
        logic [6:0] v;
        if (inv) return {1'b1, bt, bo, 15'd0};
        d1 = bt ? 4'd0 : 4'(t);
        d0 = bo ? 4'd0 : 4'(o);
        v  = 7'(int'(d1) * 10 + int'(d0));
        return {1'b0, bt, bo, d1, d0, v};
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic drive(logic [6:0] a, logic [6:0] b);
        hex1_in = a;
        hex0_in = b;
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Transfer happens on the next rising edge; compare against head
    always @(negedge clock) begin
        if (resetn && out_valid && out_ready) begin
            chk("sb_avail", 32'(sbq.size() != 0), 32'd1);
            if (sbq.size() != 0) begin
                chk("sb_result",
                    32'({out_invalid, blank1, blank0, digit1, digit0, value}),
                    32'(sbq.pop_front()));
            end
        end
    end

    initial begin
        resetn    = 1'b0;
        out_ready = 1'b1;
        drive(BLK, seg[5]);
        #2;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_value", 32'(value), 0);
        chk("rst_count", 32'(accept_count), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_blank1", 32'(blank1), 0);
        chk("rst_inv", 32'(out_invalid), 0);
        resetn = 1'b1;

        // blank/5: valid rises 3 edges after the first sample, 1 cycle
        sbq.push_back(exp_res(0, 5, 1, 0, 0));
        step(3);
        chk("lat_early", 32'(out_valid), 0);
        step(1);
        chk("lat_valid", 32'(out_valid), 1);
        chk("v5_value", 32'(value), 5);
        chk("v5_blank1", 32'(blank1), 1);
        chk("v5_blank0", 32'(blank0), 0);
        chk("v5_count", 32'(accept_count), 1);
        step(1);
        chk("v5_pulse", 32'(out_valid), 0);

        // 29 accepted, then 18 glitch and return to 29: nothing new
        drive(seg[2], seg[9]);
        sbq.push_back(exp_res(2, 9, 0, 0, 0));
        step(4);
        chk("v29_valid", 32'(out_valid), 1);
        chk("v29_value", 32'(value), 29);
        drive(seg[1], seg[8]);
        step(2);
        drive(seg[2], seg[9]);
        step(8);
        chk("glitch_count", 32'(accept_count), 2);
        chk("glitch_valid", 32'(out_valid), 0);

        // 42 held, 73 dropped
        out_ready = 1'b0;
        drive(seg[4], seg[2]);
        sbq.push_back(exp_res(4, 2, 0, 0, 0));
        step(4);
        chk("v42_valid", 32'(out_valid), 1);
        drive(seg[7], seg[3]);
        step(4);
        chk("drop_value", 32'(value), 42);
        chk("drop_ovf", 32'(overflow), 1);
        chk("drop_count", 32'(accept_count), 4);
        chk("drop_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        chk("xfer_valid", 32'(out_valid), 0);
        chk("xfer_value", 32'(value), 42);

        // Fresh start, then transfer and accept on the same edge
        resetn = 1'b0;
        #1;
        chk("rst2_ovf", 32'(overflow), 0);
        resetn = 1'b1;
        drive(seg[4], seg[2]);
        sbq.push_back(exp_res(4, 2, 0, 0, 0));
        step(4);
        chk("hold42_valid", 32'(out_valid), 1);
        drive(seg[6], seg[0]);
        sbq.push_back(exp_res(6, 0, 0, 0, 0));
        step(3);
        chk("pre60_value", 32'(value), 42);
        out_ready = 1'b1;
        step(1);
        chk("v60_valid", 32'(out_valid), 1);
        chk("v60_value", 32'(value), 60);
        chk("v60_ovf", 32'(overflow), 0);
        chk("v60_count", 32'(accept_count), 2);
        step(1);
        chk("v60_done", 32'(out_valid), 0);

        // Invalid ones pattern
        drive(seg[1], 7'b1111110);
        sbq.push_back(exp_res(0, 0, 0, 0, 1));
        step(4);
        chk("inv_valid", 32'(out_valid), 1);
        chk("inv_flag", 32'(out_invalid), 1);
        chk("inv_value", 32'(value), 0);
        chk("inv_digit0", 32'(digit0), 0);
        chk("inv_digit1", 32'(digit1), 0);
        step(1);

        // Reset while holding a result and mid-filter
        out_ready = 1'b0;
        drive(seg[3], seg[7]);
        step(4);
        chk("v37_value", 32'(value), 37);
        drive(seg[8], seg[8]);
        step(2);
        resetn = 1'b0;
        drive(BLK, BLK);
        #1;
        chk("mid_valid", 32'(out_valid), 0);
        chk("mid_value", 32'(value), 0);
        chk("mid_count", 32'(accept_count), 0);
        chk("mid_digit1", 32'(digit1), 0);
        resetn = 1'b1;
        out_ready = 1'b1;
        sbq.push_back(exp_res(0, 0, 1, 1, 0));
        step(3);
        chk("blk_early", 32'(out_valid), 0);
        step(1);
        chk("blk_valid", 32'(out_valid), 1);
        chk("blk_value", 32'(value), 0);
        chk("blk_b1", 32'(blank1), 1);
        chk("blk_b0", 32'(blank0), 1);
        step(1);
        chk("blk_done", 32'(out_valid), 0);

        chk("sb_drained", 32'(sbq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
